dram_global_controller: RTL and testbench

- Front-end DRAM global controller between one core request port and four back-end (per-bank) controllers bc0..bc3.
- Accepts read/write commands from the core, decodes the target back-end from address bits and forwards the command with write data.
- Collects read data from the back-ends and returns it to the core strictly in command-issue order.

---
 rtl/dram_global_controller.sv | 247 ++++++++++++++++++++++++
 tb/tb_dram_global_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_global_controller.sv
// dram_global_controller
//   Front-end DRAM controller sitting between one core request port and four
//   back-end (per-bank) controllers bc0..bc3.
//   - A single-entry command buffer holds one core command: op, address,
//     write data and the decoded target back-end.
//   - The buffered command is forwarded to the selected back-end. A read
//     records its back-end index in an order FIFO when it dispatches.
//   - Read data is popped from back-ends strictly in FIFO (issue) order.
//     It is returned to the core one cycle after the pop.
//
// Ports
//   i_clk, i_rst                        clock, asynchronous active-high reset
//   i_command_valid / i_command         core command {op, address}, op=1 write
//   i_write_data                        core write data, qualified by command
//   o_controller_ready                  core handshake ready
//   o_read_data_valid / o_read_data     in-order read return to core
//   i_backend_controller_ready_bcN      back-end N accepts a command
//   o_frontend_command_valid_bcN        command valid to back-end N
//   o_frontend_command_bcN              buffered command (all N)
//   o_frontend_write_data_bcN           buffered write data (all N)
//   o_backend_controller_ren_bcN        pop one returned word from back-end N
//   i_returned_data_valid_bcN / _bcN    back-end N head of returned data
//
// Build option
//   BC_XOR_HASH_EN  when defined, target = address[1:0] ^ address[9:8]
//                   (needs ADDR_W >= 10); otherwise target = address[1:0].

module dram_global_controller #(
  parameter int unsigned WORD_W        = 128,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned RD_FIFO_DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_command_valid,
  input  logic [ADDR_W:0]   i_command,
  input  logic [WORD_W-1:0] i_write_data,
  output logic              o_controller_ready,
  output logic              o_read_data_valid,
  output logic [WORD_W-1:0] o_read_data,

  input  logic              i_backend_controller_ready_bc0,
  input  logic              i_backend_controller_ready_bc1,
  input  logic              i_backend_controller_ready_bc2,
  input  logic              i_backend_controller_ready_bc3,

  output logic              o_frontend_command_valid_bc0,
  output logic              o_frontend_command_valid_bc1,
  output logic              o_frontend_command_valid_bc2,
  output logic              o_frontend_command_valid_bc3,

  output logic [ADDR_W:0]   o_frontend_command_bc0,
  output logic [ADDR_W:0]   o_frontend_command_bc1,
  output logic [ADDR_W:0]   o_frontend_command_bc2,
  output logic [ADDR_W:0]   o_frontend_command_bc3,

  output logic [WORD_W-1:0] o_frontend_write_data_bc0,
  output logic [WORD_W-1:0] o_frontend_write_data_bc1,
  output logic [WORD_W-1:0] o_frontend_write_data_bc2,
  output logic [WORD_W-1:0] o_frontend_write_data_bc3,

  output logic              o_backend_controller_ren_bc0,
  output logic              o_backend_controller_ren_bc1,
  output logic              o_backend_controller_ren_bc2,
  output logic              o_backend_controller_ren_bc3,

  input  logic              i_returned_data_valid_bc0,
  input  logic              i_returned_data_valid_bc1,
  input  logic              i_returned_data_valid_bc2,
  input  logic              i_returned_data_valid_bc3,

  input  logic [WORD_W-1:0] i_returned_data_bc0,
  input  logic [WORD_W-1:0] i_returned_data_bc1,
  input  logic [WORD_W-1:0] i_returned_data_bc2,
  input  logic [WORD_W-1:0] i_returned_data_bc3
);

  localparam int unsigned PTR_W = $clog2(RD_FIFO_DEPTH);

  typedef enum logic {
    BUF_EMPTY,
    BUF_FULL
  } buf_state_t;

  buf_state_t state, next_state;

  // Command buffer contents
  logic [ADDR_W:0]   buf_cmd;
  logic [WORD_W-1:0] buf_data;
  logic [1:0]        buf_sel;
  logic              buf_valid;
  logic              buf_op;

  // Back-end side gathered into vectors
  logic [3:0]        bc_ready;
  logic [3:0]        ret_valid;
  logic [WORD_W-1:0] ret_data [4];
  logic [3:0]        fe_valid;
  logic [3:0]        ren;

  // Order FIFO
  logic [1:0]        order_mem [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        head;

  logic [1:0]        in_sel;
  logic              dispatch_ok;
  logic              fire;
  logic              ready;
  logic              accept;
  logic              push;
  logic              pop;

  assign bc_ready  = {i_backend_controller_ready_bc3, i_backend_controller_ready_bc2,
                      i_backend_controller_ready_bc1, i_backend_controller_ready_bc0};
  assign ret_valid = {i_returned_data_valid_bc3, i_returned_data_valid_bc2,
                      i_returned_data_valid_bc1, i_returned_data_valid_bc0};
  assign ret_data[0] = i_returned_data_bc0;
  assign ret_data[1] = i_returned_data_bc1;
  assign ret_data[2] = i_returned_data_bc2;
  assign ret_data[3] = i_returned_data_bc3;

  // Target back-end decode of the incoming command
  always_comb begin
`ifdef BC_XOR_HASH_EN
    in_sel = i_command[1:0] ^ i_command[9:8];
`else
    in_sel = i_command[1:0];
`endif
  end

  assign buf_valid  = (state == BUF_FULL);
  assign buf_op     = buf_cmd[ADDR_W];
  assign fifo_full  = (count == (PTR_W+1)'(RD_FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign head       = order_mem[rd_ptr];

  // Valid toward the back-end is independent of its ready; a read is held
  // back only while the order FIFO has no room for its tag.
  assign dispatch_ok = buf_valid && (buf_op || !fifo_full);
  assign fire        = dispatch_ok && bc_ready[buf_sel];
  assign push        = fire && !buf_op;
  assign pop         = !fifo_empty && ret_valid[head];

  always_comb begin
    fe_valid = '0;
    ren      = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      fe_valid[n] = dispatch_ok && (buf_sel == 2'(n));
      ren[n]      = pop && (head == 2'(n));
    end
  end

  // Buffer occupancy FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= BUF_EMPTY;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = !i_rst && (!buf_valid || fire);
    accept     = i_command_valid && ready;
    case (state)
      BUF_EMPTY: if (accept) next_state = BUF_FULL;
      BUF_FULL: begin
        // A new command replaces a departing one in the same cycle.
        if (accept)    next_state = BUF_FULL;
        else if (fire) next_state = BUF_EMPTY;
      end
      default: next_state = BUF_EMPTY;
    endcase
  end

  assign o_controller_ready = ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_cmd  <= '0;
      buf_data <= '0;
      buf_sel  <= '0;
    end else if (accept) begin
      buf_cmd  <= i_command;
      buf_data <= i_write_data;
      buf_sel  <= in_sel;
    end
  end

  // Order FIFO: storage without reset, pointers and count with reset.
  always_ff @(posedge i_clk) begin
    if (push) order_mem[wr_ptr] <= buf_sel;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Read return to core, one cycle after the back-end pop
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_read_data_valid <= 1'b0;
      o_read_data       <= '0;
    end else if (pop) begin
      o_read_data_valid <= 1'b1;
      o_read_data       <= ret_data[head];
    end else begin
      o_read_data_valid <= 1'b0;
    end
  end

  assign o_frontend_command_valid_bc0 = fe_valid[0];
  assign o_frontend_command_valid_bc1 = fe_valid[1];
  assign o_frontend_command_valid_bc2 = fe_valid[2];
  assign o_frontend_command_valid_bc3 = fe_valid[3];

  assign o_frontend_command_bc0 = buf_cmd;
  assign o_frontend_command_bc1 = buf_cmd;
  assign o_frontend_command_bc2 = buf_cmd;
  assign o_frontend_command_bc3 = buf_cmd;

  assign o_frontend_write_data_bc0 = buf_data;
  assign o_frontend_write_data_bc1 = buf_data;
  assign o_frontend_write_data_bc2 = buf_data;
  assign o_frontend_write_data_bc3 = buf_data;

  assign o_backend_controller_ren_bc0 = ren[0];
  assign o_backend_controller_ren_bc1 = ren[1];
  assign o_backend_controller_ren_bc2 = ren[2];
  assign o_backend_controller_ren_bc3 = ren[3];

endmodule

// File: tb/tb_dram_global_controller.sv
// Testbench for dram_global_controller: directed stimulus, with dispatches
// and read returns checked against expectation queues by a monitor.
module tb_dram_global_controller;

  localparam int WORD_W = 128;
  localparam int ADDR_W = 32;

`ifdef BC_XOR_HASH_EN
  localparam int HASH_BC = 0;
`else
  localparam int HASH_BC = 1;
`endif

  typedef struct {
    int                bc;
    logic [ADDR_W:0]   cmd;
    logic [WORD_W-1:0] data;
  } disp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic [ADDR_W:0]   cmd;
  logic [WORD_W-1:0] wdata;
  logic              ready;
  logic              rdv;
  logic [WORD_W-1:0] rdata;
  logic [3:0]        bc_ready;
  logic [3:0]        fe_valid;
  logic [ADDR_W:0]   fe_cmd [4];
  logic [WORD_W-1:0] fe_data [4];
  logic [3:0]        ren;
  logic [3:0]        ret_valid;
  logic [WORD_W-1:0] ret_data [4];

  logic [WORD_W-1:0] ret_q [4][$];
  logic [3:0]        ren_q;
  disp_t             exp_disp [$];
  logic [WORD_W-1:0] exp_rd [$];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dram_global_controller #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .RD_FIFO_DEPTH(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_command_valid(cmd_valid), .i_command(cmd), .i_write_data(wdata),
    .o_controller_ready(ready), .o_read_data_valid(rdv), .o_read_data(rdata),
    .i_backend_controller_ready_bc0(bc_ready[0]), .i_backend_controller_ready_bc1(bc_ready[1]),
    .i_backend_controller_ready_bc2(bc_ready[2]), .i_backend_controller_ready_bc3(bc_ready[3]),
    .o_frontend_command_valid_bc0(fe_valid[0]), .o_frontend_command_valid_bc1(fe_valid[1]),
    .o_frontend_command_valid_bc2(fe_valid[2]), .o_frontend_command_valid_bc3(fe_valid[3]),
    .o_frontend_command_bc0(fe_cmd[0]), .o_frontend_command_bc1(fe_cmd[1]),
    .o_frontend_command_bc2(fe_cmd[2]), .o_frontend_command_bc3(fe_cmd[3]),
    .o_frontend_write_data_bc0(fe_data[0]), .o_frontend_write_data_bc1(fe_data[1]),
    .o_frontend_write_data_bc2(fe_data[2]), .o_frontend_write_data_bc3(fe_data[3]),
    .o_backend_controller_ren_bc0(ren[0]), .o_backend_controller_ren_bc1(ren[1]),
    .o_backend_controller_ren_bc2(ren[2]), .o_backend_controller_ren_bc3(ren[3]),
    .i_returned_data_valid_bc0(ret_valid[0]), .i_returned_data_valid_bc1(ret_valid[1]),
    .i_returned_data_valid_bc2(ret_valid[2]), .i_returned_data_valid_bc3(ret_valid[3]),
    .i_returned_data_bc0(ret_data[0]), .i_returned_data_bc1(ret_data[1]),
    .i_returned_data_bc2(ret_data[2]), .i_returned_data_bc3(ret_data[3])
  );

  task automatic check(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: got event with no expectation at %0t", name, $time);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Back-end model: per-bank return queues, popped on a sampled ren.
  always @(posedge clk) ren_q <= ren;

  initial begin
    ret_valid = '0;
    for (int n = 0; n < 4; n++) ret_data[n] = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int n = 0; n < 4; n++) begin
        if (ren_q[n] && ret_q[n].size() != 0) void'(ret_q[n].pop_front());
        ret_valid[n] = (ret_q[n].size() != 0);
        ret_data[n]  = ret_valid[n] ? ret_q[n][0] : '0;
      end
    end
  end

  // Monitor: every dispatch and every read return is checked in order.
  int    hits;
  int    idx;
  disp_t e_mon;

  always @(negedge clk) begin
    if (!rst) begin
      hits = 0;
      idx  = 0;
      for (int n = 0; n < 4; n++) begin
        if (fe_valid[n]) begin
          hits++;
          idx = n;
        end
      end
      if (hits > 1) check("one_hot_valid", 128'(fe_valid), 128'(1) << idx);
      if (hits == 1 && bc_ready[idx]) begin
        if (exp_disp.size() == 0) fail("disp_unexpected");
        else begin
          e_mon = exp_disp.pop_front();
          check("disp_bc", 128'(idx), 128'(e_mon.bc));
          check("disp_cmd", 128'(fe_cmd[idx]), 128'(e_mon.cmd));
          check("disp_data", fe_data[idx], e_mon.data);
        end
      end
      if (rdv) begin
        if (exp_rd.size() == 0) fail("rd_unexpected");
        else check("rd_data", rdata, exp_rd.pop_front());
      end
    end
  end

  task automatic send(input bit op, input logic [ADDR_W-1:0] addr,
                      input logic [WORD_W-1:0] d, input int bc);
    disp_t e;
    bit    acc;
    int    n;
    e.bc = bc;
    e.cmd = {op, addr};
    e.data = d;
    exp_disp.push_back(e);
    cmd_valid = 1'b1;
    cmd = {op, addr};
    wdata = d;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit acc;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd = '0;
    wdata = '0;
    bc_ready = '0;

    // Reset state
    @(negedge clk);
    check("rst_ready", 128'(ready), 0);
    check("rst_fe_valid", 128'(fe_valid), 0);
    check("rst_ren", 128'(ren), 0);
    check("rst_rdv", 128'(rdv), 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 128'(ready), 1);
    @(posedge clk); #1;

    // Single write to bc2
    bc_ready = 4'b0100;
    send(1'b1, 32'h2, {16{8'hA5}}, 2);
    @(negedge clk);
    check("wr_valid_bc2", 128'(fe_valid), 128'(4'b0100));
    check("wr_cmd", 128'(fe_cmd[2]), 128'({1'b1, 32'h2}));
    check("wr_ready_stays", 128'(ready), 1);
    step(2);

    // Read to bc1 stalled by back-end ready, second command held off
    bc_ready = 4'b1101;
    send(1'b0, 32'h1, 128'h0, 1);
    exp_rd.push_back(128'hB1);
    cmd_valid = 1'b1;
    cmd = {1'b1, 32'h4};
    wdata = 128'hC4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid_bc1", 128'(fe_valid), 128'(4'b0010));
      check("stall_ready", 128'(ready), 0);
      @(posedge clk); #1;
    end
    exp_disp.push_back('{bc: 0, cmd: {1'b1, 32'h4}, data: 128'hC4});
    bc_ready = 4'b1111;
    @(negedge clk);
    check("stall_release_ready", 128'(ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    step(2);
    ret_q[1].push_back(128'hB1);
    step(4);

    // Out-of-order return: bc3 read then bc0 read, bc0 answers first
    send(1'b0, 32'h3, 128'h0, 3);
    exp_rd.push_back(128'h33);
    send(1'b0, 32'h0, 128'h0, 0);
    exp_rd.push_back(128'h11);
    step(2);
    ret_q[0].push_back(128'h11);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ooo_no_ren", 128'(ren), 0);
      check("ooo_no_rdv", 128'(rdv), 0);
      @(posedge clk); #1;
    end
    ret_q[3].push_back(128'h33);
    @(negedge clk);
    check("ooo_ren_bc3", 128'(ren), 128'(4'b1000));
    @(posedge clk); #1;
    @(negedge clk);
    check("ooo_lat_bc3", 128'(rdv), 1);
    check("ooo_ren_bc0", 128'(ren), 128'(4'b0001));
    @(posedge clk); #1;
    @(negedge clk);
    check("ooo_lat_bc0", 128'(rdv), 1);
    @(posedge clk); #1;
    step(2);

    // Order FIFO full: 8 reads dispatch, the 9th waits for a pop
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 32'(i), 128'h0, i % 4);
      exp_rd.push_back(128'h500 + 128'(i));
    end
    send(1'b0, 32'h8, 128'h0, 0);
    exp_rd.push_back(128'h508);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("full_hold_valid", 128'(fe_valid), 0);
      check("full_hold_ready", 128'(ready), 0);
      @(posedge clk); #1;
    end
    ret_q[0].push_back(128'h500);
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clk);
      acc = (fe_valid == 4'b0001);
      @(posedge clk); #1;
    end
    check("full_resume", 128'(acc), 1);
    for (int i = 1; i < 8; i++) ret_q[i % 4].push_back(128'h500 + 128'(i));
    ret_q[0].push_back(128'h508);
    step(20);

    // Target hashing
    send(1'b1, 32'h101, 128'hDEAD, HASH_BC);
    @(negedge clk);
    check("hash_valid", 128'(fe_valid), 128'(1) << HASH_BC);
    @(posedge clk); #1;
    step(2);

    // Reset mid-operation drops buffered command and read ordering
    send(1'b0, 32'h2, 128'h0, 2);
    step(1);
    bc_ready = 4'b0111;
    send(1'b1, 32'h3, 128'h99, 3);
    @(negedge clk);
    check("pre_rst_valid_bc3", 128'(fe_valid), 128'(4'b1000));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_disp.delete();
    exp_rd.delete();
    @(negedge clk);
    check("mid_rst_valid", 128'(fe_valid), 0);
    check("mid_rst_ready", 128'(ready), 0);
    check("mid_rst_rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bc_ready = 4'b1111;
    ret_q[2].push_back(128'h77);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_ren", 128'(ren), 0);
      check("post_rst_no_valid", 128'(fe_valid), 0);
      @(posedge clk); #1;
    end
    ret_q[2].delete();
    step(2);

    check("disp_drained", 128'(exp_disp.size()), 0);
    check("rd_drained", 128'(exp_rd.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
